// File: rtl/adc_i2s_tx.sv
// adc_i2s_tx: buffers decimated ADC samples in a small FIFO and streams them as a mono I2S frame
// (sample duplicated in left and right slots); this block is the I2S master and derives sck from clk.
module adc_i2s_tx #(
   parameter int ADC_BITLEN = 24,
   parameter int SLOT_BITS  = 32,
   parameter int BCLK_DIV   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADC_BITLEN-1:0]       adc_output,
   input  logic                        adc_valid,
   output logic                        i2s_sck,
   output logic                        i2s_ws,
   output logic                        i2s_sd,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow,
   output logic                        underrun
);
   localparam int FRAME = 2 * SLOT_BITS;
   localparam int CW = $clog2(FRAME);
   localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0]         div_cnt;
   logic [CW-1:0]         c, c_nxt, j;
   logic [ADC_BITLEN-1:0] hold, sh;
   logic [ADC_BITLEN-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  wrap, fall, frame_start, empty, full, pop, push, ws_nxt, sd_nxt;

   // The bit sent at position c_nxt uses k = c_nxt-1, which is simply the current c.
   always_comb begin
      wrap = div_cnt == DW'(BCLK_DIV - 1);
      fall = wrap & i2s_sck;
      c_nxt = (c == CW'(FRAME - 1)) ? '0 : c + CW'(1);
      frame_start = fall & (c_nxt == '0);
      empty = fifo_level == '0;
      full = fifo_level == LW'(FIFO_DEPTH);
      pop = frame_start & ~empty;
      push = adc_valid & (~full | pop);
      j = (c >= CW'(SLOT_BITS)) ? c - CW'(SLOT_BITS) : c;
      sh = hold << j;
      sd_nxt = (j < CW'(ADC_BITLEN)) & sh[ADC_BITLEN-1];
      ws_nxt = c_nxt >= CW'(SLOT_BITS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         i2s_sck <= 1'b0;
         c <= '0;
         i2s_ws <= 1'b0;
         i2s_sd <= 1'b0;
         hold <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         fifo_level <= '0;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         div_cnt <= wrap ? '0 : div_cnt + DW'(1);
         if (wrap) i2s_sck <= ~i2s_sck;
         if (fall) begin
            c <= c_nxt;
            i2s_ws <= ws_nxt;
            i2s_sd <= sd_nxt;
         end
         if (pop) begin
            hold <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
         overflow <= adc_valid & full & ~pop;
         underrun <= frame_start & empty;
      end
   end

   // Storage needs no reset: the pointers and level define which entries are live.
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= adc_output;
endmodule

// File: tb/tb_adc_i2s_tx.sv
// tb_adc_i2s_tx: randomized bench checking every output each cycle against a queue-based frame model
// derived from edge counts since reset release.
module tb_adc_i2s_tx;
   localparam int W = 24, SB = 32, DIV = 2, DEPTH = 4;
   localparam int FRAME_CLK = 2 * SB * 2 * DIV;

   logic          clk = 1'b0, rst = 1'b1, adc_valid = 1'b0;
   logic [W-1:0]  adc_output = '0;
   logic          i2s_sck, i2s_ws, i2s_sd, overflow, underrun;
   logic [2:0]    fifo_level;
   int            n_checks = 0, n_pass = 0, n = 0;
   logic [W-1:0]  q [$];
   logic [W-1:0]  hold_m = '0;
   logic          exp_ovf = 1'b0, exp_und = 1'b0;

   always #5 clk = ~clk;

   adc_i2s_tx #(.ADC_BITLEN(W), .SLOT_BITS(SB), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .adc_output(adc_output), .adc_valid(adc_valid),
      .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .fifo_level(fifo_level),
      .overflow(overflow), .underrun(underrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_sck"}, 32'(i2s_sck), 32'(0));
      check({tag, "_ws"}, 32'(i2s_ws), 32'(0));
      check({tag, "_sd"}, 32'(i2s_sd), 32'(0));
      check({tag, "_level"}, 32'(fifo_level), 32'(0));
      check({tag, "_ovf"}, 32'(overflow), 32'(0));
      check({tag, "_und"}, 32'(underrun), 32'(0));
   endtask

   // Slot position follows from the edge count: one sck period is 2*DIV clk edges.
   task automatic check_outputs();
      int cb, j;
      logic e_sd;
      cb = (n / (2 * DIV)) % (2 * SB);
      j = ((cb + 2 * SB - 1) % (2 * SB)) % SB;
      e_sd = (j < W) ? 1'(hold_m >> (W - 1 - j)) : 1'b0;
      check("sck", 32'(i2s_sck), 32'((n / DIV) % 2));
      check("ws", 32'(i2s_ws), 32'(cb >= SB));
      check("sd", 32'(i2s_sd), 32'(e_sd));
      check("level", 32'(fifo_level), 32'(q.size()));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("underrun", 32'(underrun), 32'(exp_und));
   endtask

   task automatic tick(input logic v, input logic [W-1:0] d);
      check_outputs();
      adc_valid = v;
      adc_output = d;
      @(posedge clk);
      n++;
      exp_ovf = 1'b0;
      exp_und = 1'b0;
      if (n % FRAME_CLK == 0) begin
         if (q.size() > 0) hold_m = q.pop_front();
         else exp_und = 1'b1;
      end
      if (v) begin
         if (q.size() < DEPTH) q.push_back(d);
         else exp_ovf = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic run_to(input int t);
      while (n < t) tick(1'b0, '0);
   endtask

   task automatic restart();
      n = 0;
      q.delete();
      hold_m = '0;
      exp_ovf = 1'b0;
      exp_und = 1'b0;
   endtask

   initial begin
      logic [W-1:0] base;
      repeat (20) begin
         @(negedge clk);
         check_zero("rst");
         adc_valid = 1'($urandom);
         adc_output = W'($urandom);
      end
      adc_valid = 1'b0;
      rst = 1'b0;
      restart();
      run_to(10);
      tick(1'b1, 24'hA5C3F0);
      run_to(3 * FRAME_CLK + 10);
      tick(1'b1, 24'h000001);
      run_to(5 * FRAME_CLK + 10);
      base = W'($urandom);
      for (int i = 0; i < 5; i++) tick(1'b1, base + W'(i));
      run_to(10 * FRAME_CLK + 10);
      for (int i = 0; i < 4; i++) tick(1'b1, W'($urandom));
      run_to(11 * FRAME_CLK - 1);
      tick(1'b1, 24'h5A5A5A);
      run_to(16 * FRAME_CLK + 10);
      while (n < 28 * FRAME_CLK) begin
         if ($urandom_range(0, 149) == 0) tick(1'b1, W'($urandom));
         else tick(1'b0, '0);
      end
      tick(1'b1, W'($urandom));
      tick(1'b1, W'($urandom));
      while (n % FRAME_CLK != 41) tick(1'b0, '0);
      #1 rst = 1'b1;
      #1 check_zero("async_rst");
      repeat (3) @(negedge clk);
      check_zero("async_hold");
      rst = 1'b0;
      restart();
      run_to(2 * FRAME_CLK + 10);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/adc_i2s_tx.md
# adc_i2s_tx

Serial audio transmitter that sits directly downstream of `sigma_delta_adc`. It accepts each decimated `adc_output` word on its `adc_valid` pulse and buffers it in a small FIFO. It then streams the word as a standard I2S frame (mono sample duplicated in left and right slots) so an external codec or MCU can capture the converter output. All I2S clocks are generated internally from `clk`. The block is the I2S master.

## Interface
- `ADC_BITLEN`, 24: sample width; must be < `SLOT_BITS`.
- `SLOT_BITS`, 32: I2S bits per channel slot; frame = 2*`SLOT_BITS` sck periods.
- `BCLK_DIV`, 2: `clk` cycles per sck half-period, ≥1.
- `FIFO_DEPTH`, 4: sample buffer depth; power of 2, ≥2.
- `clk` input 1: single system clock; also the ADC bit clock.
- `rst` input 1: reset, asynchronous, active-high.
- `adc_output` input `ADC_BITLEN`: sample from `sigma_delta_adc`, unsigned, transmitted unmodified.
- `adc_valid` input 1: one-`clk` pulse; `adc_output` is valid in that cycle.
- `i2s_sck` output 1: bit clock, period 2*`BCLK_DIV` `clk` cycles.
- `i2s_ws` output 1: word select; 0 = left, 1 = right.
- `i2s_sd` output 1: serial data, MSB first.
- `fifo_level` output $clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `overflow` output 1: one-`clk` pulse when an incoming sample is dropped.
- `underrun` output 1: one-`clk` pulse when a frame starts with an empty FIFO.

## Operation
- **Divider**
  - `div_cnt` counts 0..`BCLK_DIV`-1 and wraps.
  - On wrap, `i2s_sck` toggles.
  - A high→low toggle is a *fall event*.
- **Bit counter**
  - `c` ranges 0..2*`SLOT_BITS`-1.
  - On each fall event, `c` ← (`c`+1) mod 2*`SLOT_BITS`.
  - `i2s_ws` and `i2s_sd` update in that same `clk` cycle from the new `c`.
- **Word select:** `i2s_ws` = (`c` ≥ `SLOT_BITS`).
- **Serial data**
  - k = (`c`−1) mod 2*`SLOT_BITS`; j = k mod `SLOT_BITS`.
  - `i2s_sd` = `hold`[`ADC_BITLEN`−1−j] if j < `ADC_BITLEN`, else 0.
  - This gives standard I2S: MSB one sck after the ws edge, zero-padded tail.
- **Frame start**
  - A fall event that makes `c`=0 pops the FIFO head into `hold`.
  - If the FIFO is empty, `hold` keeps its previous value and `underrun` pulses.
  - `hold` is never modified mid-frame.
  - The bit emitted at `c`=0 is always padding, because `ADC_BITLEN` < `SLOT_BITS`.
- **FIFO write**
  - `adc_valid` with FIFO not full: write `adc_output` at the tail; level +1.
  - `adc_valid` with FIFO full and no pop that cycle: drop the sample; `overflow` pulses; level unchanged.
- **Simultaneous push and pop:** both take effect.
  - Level is unchanged.
  - When full, the push is accepted and there is no `overflow`.
  - When empty, the pop underruns and the push is stored; level becomes 1.
- **Ordering:** samples are transmitted strictly in arrival order.

## Timing
- **Reset values** (asynchronous, no `clk` edge needed):
  - `i2s_sck`=0, `i2s_ws`=0, `i2s_sd`=0, `fifo_level`=0, `overflow`=0, `underrun`=0.
  - Internal: `div_cnt`=0, `c`=0, `hold`=0, FIFO pointers cleared.
- **After reset release:**
  - First sck rise occurs at the `BCLK_DIV`-th `clk` edge.
  - Fall event n occurs at `clk` edge 2*`BCLK_DIV`*n.
  - The first pop happens at fall event 2*`SLOT_BITS`.
- **Latency**
  - A sample's MSB appears on `i2s_sd` one fall event after the pop that loads it.
  - `fifo_level` updates the `clk` cycle after the push or pop.
- **Outputs**
  - `i2s_sd` and `i2s_ws` are registered and change only in fall-event cycles.
  - `overflow` and `underrun` are registered one-cycle pulses.
- **Rate matching:** with defaults, a frame is 256 `clk` cycles, exactly one ADC sample at OVERSAMPLE_RATE=256.
- **Reset mid-frame:** frame is abandoned, buffered samples are discarded, and sequencing restarts as from power-up.

## Test plan
- **Reset:** hold `rst` 20 cycles, then release mid-stream → all outputs 0 during `rst`. After release, `i2s_sck` first rises at edge 2 and falls at edge 4 (defaults); `i2s_ws` stays 0 for 32 sck.
- **Single sample:** push 0xA5C3F0 before the first pop → in the next frame, left-slot bits `c`=1..24 = 0xA5C3F0 MSB-first, `c`=25..31 = 0. Right slot `c`=33..56 is identical; `i2s_ws` rises at `c`=32.
- **Underrun:** no pushes → `i2s_sd` stays 0 and `underrun` pulses once per frame. After pushing 0x000001 once, the next two frames both carry 0x000001; the second frame also raises `underrun`.
- **Overflow:** push 5 distinct samples back-to-back before any pop → 5th dropped, `overflow` one pulse, `fifo_level`=4. The next 4 frames carry samples 1–4 in order.
- **Simultaneous push/pop:** FIFO full, `adc_valid` on the pop cycle → no `overflow`, `fifo_level` stays 4, and the new sample is transmitted 4 frames later.
- **Async reset mid-frame:** assert `rst` at `c`=10 between `clk` edges → outputs go 0 immediately and `fifo_level`=0. After release, the first frame carries zeros with `underrun`.
